calc_op_engine: RTL and testbench

Operator-input and arithmetic stage directly upstream of the LCD writer. It conditions the four push-buttons, runs the OFF/ON/ADD/SUBTRACT/MULTIPLY mode state machine, and computes a sign-magnitude result from two 8-bit sign-magnitude operands. It presents `oper`, `sinal_s` and `s` as stable registered values that the LCD stage samples at any time.

---
 rtl/calc_op_engine.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_calc_op_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_engine.sv
// ---------------------------------------------------------------------------
// calc_op_engine
//
// Operator-input and arithmetic stage feeding the LCD writer. Conditions the
// four push-buttons, runs the OFF/ON/ADD/SUBTRACT/MULTIPLY mode FSM and
// produces a registered sign-magnitude result from two 8-bit sign-magnitude
// operands.
//
// Optional feature: define CALC_DEBOUNCE_EN to insert a per-button debounce
// counter of DEBOUNCE_CYCLES stable cycles after the synchronizer. Without
// it the synchronized level is used directly and DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   button_enable        power toggle (asynchronous push-button)
//   button_soma          select ADD
//   button_subtracao     select SUBTRACT
//   button_multiplicacao select MULTIPLY
//   sinal_a, sinal_b     operand signs (1 = negative)
//   a, b                 operand magnitudes
//   oper                 mode: OFF=0 ON=1 ADD=2 SUBTRACT=3 MULTIPLY=4
//   sinal_s              result sign
//   s                    result magnitude
//   busy                 multiplier iterating
//   done                 one-cycle pulse when s/sinal_s take a new value
// ---------------------------------------------------------------------------
module calc_op_engine #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button_enable,
    input  logic        button_soma,
    input  logic        button_subtracao,
    input  logic        button_multiplicacao,
    input  logic        sinal_a,
    input  logic        sinal_b,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [2:0]  oper,
    output logic        sinal_s,
    output logic [15:0] s,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StOff = 3'd0,
        StOn  = 3'd1,
        StAdd = 3'd2,
        StSub = 3'd3,
        StMul = 3'd4
    } state_e;

    // Button vector bit positions.
    localparam int BtnEn   = 0;
    localparam int BtnMul  = 1;
    localparam int BtnSoma = 2;
    localparam int BtnSub  = 3;

    logic [3:0] btn_raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] btn_level;
    logic [3:0] prev_q;
    logic [3:0] edge_q;

    assign btn_raw = {button_subtracao, button_soma, button_multiplicacao, button_enable};

    // -----------------------------------------------------------------------
    // Two-flop synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Level conditioning
    // -----------------------------------------------------------------------
`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CntW-1:0] cnt_q;
        logic            level_q;

        // The counter runs only while the synchronized level disagrees with
        // the accepted one; any return to agreement reloads it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (sync2_q[i] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign btn_level[i] = level_q;
    end
`else
    assign btn_level = sync2_q;
`endif

    // -----------------------------------------------------------------------
    // Registered rising-edge detector (press only, no auto-repeat)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            prev_q <= btn_level;
            edge_q <= btn_level & ~prev_q;
        end
    end

    // -----------------------------------------------------------------------
    // Mode FSM
    // -----------------------------------------------------------------------
    state_e state_q, state_d;
    logic   mul_start_q, mul_start_d;

    always_comb begin
        state_d     = state_q;
        mul_start_d = 1'b0;
        if (edge_q[BtnEn]) begin
            state_d = (state_q == StOff) ? StOn : StOff;
        end else if (state_q != StOff) begin
            if (edge_q[BtnMul]) begin
                state_d     = StMul;
                mul_start_d = 1'b1;  // entry or reselection restarts the run
            end else if (edge_q[BtnSoma]) begin
                state_d = StAdd;
            end else if (edge_q[BtnSub]) begin
                state_d = StSub;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StOff;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_start_q <= mul_start_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sign-magnitude adder (SUBTRACT = ADD with b's sign inverted)
    // -----------------------------------------------------------------------
    logic       sb_eff;
    logic [8:0] add_mag;
    logic       add_sign;

    always_comb begin
        sb_eff   = sinal_b ^ (state_q == StSub);
        add_mag  = '0;
        add_sign = 1'b0;
        if (sinal_a == sb_eff) begin
            add_mag  = {1'b0, a} + {1'b0, b};
            add_sign = sinal_a;
        end else if (a >= b) begin
            add_mag  = {1'b0, a - b};
            add_sign = sinal_a;
        end else begin
            add_mag  = {1'b0, b - a};
            add_sign = sb_eff;
        end
        if (add_mag == 9'd0) begin
            add_sign = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Result registers and shift-add multiplier
    // -----------------------------------------------------------------------
    logic [15:0] s_q, s_d;
    logic        sign_q, sign_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [3:0]  iter_q, iter_d;
    logic [7:0]  a_lat_q, a_lat_d;
    logic [7:0]  b_lat_q, b_lat_d;
    logic        sa_lat_q, sa_lat_d;
    logic        sb_lat_q, sb_lat_d;
    logic        op_diff;

    assign op_diff = (a != a_lat_q) || (b != b_lat_q) ||
                     (sinal_a != sa_lat_q) || (sinal_b != sb_lat_q);

    always_comb begin
        s_d      = s_q;
        sign_d   = sign_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        a_lat_d  = a_lat_q;
        b_lat_d  = b_lat_q;
        sa_lat_d = sa_lat_q;
        sb_lat_d = sb_lat_q;

        case (state_q)
            StAdd, StSub: begin
                s_d    = {7'd0, add_mag};
                sign_d = add_sign;
                done_d = (s_d != s_q) || (sign_d != sign_q);
                busy_d = 1'b0;
            end
            StMul: begin
                if (state_d != StMul) begin
                    // Leaving mid-run abandons it without a done pulse.
                    busy_d = 1'b0;
                end else if (mul_start_q || op_diff) begin
                    a_lat_d  = a;
                    b_lat_d  = b;
                    sa_lat_d = sinal_a;
                    sb_lat_d = sinal_b;
                    acc_d    = '0;
                    mcand_d  = {8'd0, a};
                    mplier_d = b;
                    iter_d   = '0;
                    busy_d   = 1'b1;
                end else if (mul_start_d) begin
                    // Reselection pending: freeze until the relatch next cycle.
                end else if (busy_q) begin
                    if (iter_q == 4'd8) begin
                        s_d    = acc_q;
                        sign_d = (sa_lat_q ^ sb_lat_q) && (acc_q != 16'd0);
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        iter_d   = iter_q + 4'd1;
                    end
                end
            end
            default: begin
                s_d    = '0;
                sign_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            a_lat_q  <= '0;
            b_lat_q  <= '0;
            sa_lat_q <= 1'b0;
            sb_lat_q <= 1'b0;
        end else begin
            s_q      <= s_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            iter_q   <= iter_d;
            a_lat_q  <= a_lat_d;
            b_lat_q  <= b_lat_d;
            sa_lat_q <= sa_lat_d;
            sb_lat_q <= sb_lat_d;
        end
    end

    assign oper    = state_q;
    assign s       = s_q;
    assign sinal_s = sign_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_calc_op_engine.sv
// ---------------------------------------------------------------------------
// tb_calc_op_engine
//
// Self-checking bench for calc_op_engine. Expected results are pushed to a
// scoreboard queue when stimulus is applied and popped on every done pulse.
// Debounce-specific scenarios run only when CALC_DEBOUNCE_EN is defined.
// ---------------------------------------------------------------------------
module tb_calc_op_engine;

`ifdef CALC_DEBOUNCE_EN
    localparam int Hold    = 40;
    localparam int Settle  = 30;
    localparam int LatPre  = 14;
`else
    localparam int Hold    = 6;
    localparam int Settle  = 6;
    localparam int LatPre  = 0;
`endif
    localparam int Budget = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = '0;  // 0 enable, 1 mul, 2 soma, 3 sub
    logic        sa = 1'b0, sb = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [2:0]  oper;
    logic        sinal_s;
    logic [15:0] s;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb_q[$];
    logic [16:0] last_exp = '0;

    calc_op_engine #(
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .button_enable       (btn[0]),
        .button_soma         (btn[2]),
        .button_subtracao    (btn[3]),
        .button_multiplicacao(btn[1]),
        .sinal_a             (sa),
        .sinal_b             (sb),
        .a                   (a),
        .b                   (b),
        .oper                (oper),
        .sinal_s             (sinal_s),
        .s                   (s),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference models in plain signed integer arithmetic.
    function automatic logic [16:0] model_addsub(input logic [7:0] xa, input logic xsa,
                                                 input logic [7:0] xb, input logic xsb,
                                                 input logic sub);
        int va, vb, r;
        va = xsa ? -int'(xa) : int'(xa);
        vb = xsb ? -int'(xb) : int'(xb);
        r  = sub ? va - vb : va + vb;
        if (r < 0) return {1'b1, 16'(-r)};
        return {1'b0, 16'(r)};
    endfunction

    function automatic logic [16:0] model_mul(input logic [7:0] xa, input logic xsa,
                                              input logic [7:0] xb, input logic xsb);
        int va, vb, r;
        va = xsa ? -int'(xa) : int'(xa);
        vb = xsb ? -int'(xb) : int'(xb);
        r  = va * vb;
        if (r < 0) return {1'b1, 16'(-r)};
        return {1'b0, 16'(r)};
    endfunction

    // ADD/SUB only pulse done when the value actually changes.
    task automatic push_addsub(input logic [16:0] v);
        if (v != last_exp) sb_q.push_back(v);
        last_exp = v;
    endtask

    task automatic push_mul(input logic [16:0] v);
        sb_q.push_back(v);
        last_exp = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        tick(Hold);
        btn[idx] = 1'b0;
        tick(Settle);
    endtask

    task automatic wait_oper(input logic [2:0] target, input string tag);
        int n;
        n = 0;
        while (oper !== target && n < Budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(oper), 32'(target));
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("done_result", 32'({sinal_s, s}), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_oper", 32'(oper), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_sign", 32'(sinal_s), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Power toggling; operations ignored while OFF.
        press(0);
        check("pwr_on", 32'(oper), 32'd1);
        press(0);
        check("pwr_off", 32'(oper), 32'd0);
        press(2);
        check("soma_off", 32'(oper), 32'd0);
        press(0);
        check("pwr_on2", 32'(oper), 32'd1);

        // ADD / SUB.
        a = 8'd200; sa = 1'b0; b = 8'd55; sb = 1'b1;
        tick(2);
        check("on_s_zero", 32'(s), 32'd0);
        push_addsub(model_addsub(a, sa, b, sb, 1'b0));
        press(2);
        check("add_oper", 32'(oper), 32'd2);
        check("add_s", 32'(s), 32'd145);
        check("add_sign", 32'(sinal_s), 32'd0);
        push_addsub(model_addsub(a, sa, b, sb, 1'b1));
        press(3);
        check("sub_oper", 32'(oper), 32'd3);
        check("sub_s", 32'(s), 32'd255);
        check("sub_sign", 32'(sinal_s), 32'd0);

        a = 8'd7; sa = 1'b0; b = 8'd7; sb = 1'b0;
        push_addsub(model_addsub(a, sa, b, sb, 1'b1));
        tick(3);
        check("sub_zero_s", 32'(s), 32'd0);
        check("sub_zero_sign", 32'(sinal_s), 32'd0);
        push_addsub(model_addsub(a, sa, b, sb, 1'b0));
        press(2);
        a = 8'd3; sa = 1'b0; b = 8'd10; sb = 1'b1;
        push_addsub(model_addsub(a, sa, b, sb, 1'b0));
        tick(3);
        check("add_neg_s", 32'(s), 32'd7);
        check("add_neg_sign", 32'(sinal_s), 32'd1);

        // MULTIPLY with exact latency.
        a = 8'd255; sa = 1'b1; b = 8'd255; sb = 1'b0;
        push_addsub(model_addsub(a, sa, b, sb, 1'b0));
        tick(3);
        push_mul(model_mul(a, sa, b, sb));
        btn[1] = 1'b1;
        wait_oper(3'd4, "mul_oper");
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check($sformatf("mul_busy_%0d", i), 32'(busy), 32'(i <= 9));
            check($sformatf("mul_done_%0d", i), 32'(done), 32'(i == 10));
        end
        check("mul_s", 32'(s), 32'd65025);
        check("mul_sign", 32'(sinal_s), 32'd1);
        btn[1] = 1'b0;
        tick(Settle);

        // Operand change retriggers.
        a = 8'd0;
        push_mul(model_mul(a, sa, b, sb));
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check($sformatf("mul0_done_%0d", i), 32'(done), 32'(i == 10));
        end
        check("mul0_s", 32'(s), 32'd0);
        check("mul0_sign", 32'(sinal_s), 32'd0);
        tick(2);

        // Abort by operand change mid-run.
        a = 8'd13; sa = 1'b0;
        tick(1);
        check("abort_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
        end
        b = 8'd100;
        push_mul(model_mul(a, sa, b, sb));
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check($sformatf("abort_done_%0d", i), 32'(done), 32'(i == 10));
        end
        check("abort_s", 32'(s), 32'd1300);
        check("abort_sign", 32'(sinal_s), 32'd0);
        tick(2);

        // Enable press mid-run.
        btn[0] = 1'b1;
        tick(LatPre);
        b = 8'd200;
        tick(2);
        check("en_mid_busy_pre", 32'(busy), 32'd1);
        wait_oper(3'd0, "en_mid_oper");
        check("en_mid_busy", 32'(busy), 32'd0);
        tick(2);
        check("en_mid_s", 32'(s), 32'd0);
        check("en_mid_sign", 32'(sinal_s), 32'd0);
        btn[0] = 1'b0;
        last_exp = '0;
        tick(Settle);
        check("en_mid_sb_empty", 32'(sb_q.size()), 32'd0);

        // Simultaneous soma + multiplicacao edges: MULTIPLY wins.
        press(0);
        check("pwr_on3", 32'(oper), 32'd1);
        a = 8'd2; sa = 1'b1; b = 8'd3; sb = 1'b1;
        tick(2);
        push_mul(model_mul(a, sa, b, sb));
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        wait_oper(3'd4, "simul_oper");
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        tick(15);
        check("simul_s", 32'(s), 32'd6);
        check("simul_sign", 32'(sinal_s), 32'd0);

`ifdef CALC_DEBOUNCE_EN
        // Short glitch rejected; a long press acts exactly once.
        btn[2] = 1'b1;
        tick(10);
        btn[2] = 1'b0;
        tick(40);
        check("glitch_oper", 32'(oper), 32'd4);
        begin
            int changes;
            logic [2:0] prev;
            changes = 0;
            prev = oper;
            push_addsub(model_addsub(a, sa, b, sb, 1'b0));
            btn[2] = 1'b1;
            for (int i = 0; i < 60; i++) begin
                if (i == 20) btn[2] = 1'b0;
                tick(1);
                if (oper != prev) changes++;
                prev = oper;
            end
            check("press_changes", 32'(changes), 32'd1);
            check("press_oper", 32'(oper), 32'd2);
            check("press_s", 32'(s), 32'd5);
        end
        tick(5);
`endif

        // Asynchronous reset mid-operation.
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_oper", 32'(oper), 32'd0);
        check("arst_s", 32'(s), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
